load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Consumer end of the main decoder's memory controls. Turns memwrite/resultsrc requests into
//  transactions on a valid/ready data-memory bus: lb/lh/lw/lbu/lhu/sb/sh/sw.
//  Stalls the core until each access completes. Sits between the datapath and the data memory.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    32   bus data width (fixed 32; byte enables 4 bits)
//  TIMEOUT   255  max cycles in REQ+WAIT before abort; 0 = no timeout
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, synchronous, active-low
//  memwrite_i   in   1       store request (decoder memwrite)
//  memread_i    in   1       load request (decoder resultsrc)
//  funct3_i     in   3       access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//  addr_i       in   ADDR_W  effective address (ALU result)
//  wdata_i      in   DATA_W  store data (rs2)
//  rdata_o      out  DATA_W  load result, extended; valid while state==DONE
//  stall_o      out  1       hold PC/pipeline; core inputs held stable while high
//  misalign_o   out  1       1-cycle pulse: misaligned access rejected
//  bus_err_o    out  1       1-cycle pulse (in DONE): access aborted by timeout
//  bus_valid_o  out  1       request valid
//  bus_ready_i  in   1       request accepted
//  bus_we_o     out  1       1 = write
//  bus_addr_o   out  ADDR_W  word-aligned address (addr[1:0]=00)
//  bus_be_o     out  4       byte enables
//  bus_wdata_o  out  DATA_W  store data, lane-replicated
//  bus_rvalid_i in   1       read data valid
//  bus_rdata_i  in   DATA_W  read data word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0.
//  FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//  IDLE
//   - memwrite_i|memread_i with aligned address: register we/addr/be/wdata/funct3/offset.
//     stall_o=1 combinationally this cycle. Go REQ.
//   - Both asserted: treat as write.
//   - Misaligned (h: addr[0]!=0; w: addr[1:0]!=0): misalign_o=1 for 1 cycle.
//     No bus access, no stall, stay IDLE.
//   - Illegal funct3 (011, 110, 111): treated as word size.
//  REQ: bus_valid_o=1, payload stable until bus_ready_i.
//   - Handshake: write -> DONE; read -> WAIT.
//  WAIT: bus_valid_o=0.
//   - On bus_rvalid_i: latch lane-extracted, sign/zero-extended data; go DONE.
//   - bus_rvalid_i outside WAIT is ignored.
//  DONE: stall_o=0, rdata_o valid, go IDLE.
//   - Requests in DONE are ignored: same instruction retiring.
//  Stall latency: 2 cycles minimum for a store (IDLE, REQ with ready=1);
//   3 cycles minimum for a load (rvalid in the first WAIT cycle).
//  Timeout
//   - Counter cleared on IDLE->REQ; increments each REQ/WAIT cycle.
//   - At count==TIMEOUT (TIMEOUT!=0): drop bus_valid_o, go DONE, bus_err_o=1, rdata_o=0.
//  Lanes
//   - be: b = 1<<addr[1:0]; h = 0011<<addr[1:0]; w = 1111.
//   - wdata: b = {4{wdata[7:0]}}; h = {2{wdata[15:0]}}.
//   - load: shift bus_rdata right by 8*addr[1:0], then extend per funct3.
//  rst_n low mid-transaction: abort immediately to IDLE, outputs 0.
//   The bus slave is reset by the same rst_n.
// STRUCTURE
//  riscv_pkg gets:
//   - F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU/F3_SB/F3_SH/F3_SW constants
//   - lsu_state_t enum {IDLE, REQ, WAIT, DONE}
//  Sub-module lsu_align (combinational): be/wdata generation, load extract/extend, misalign check.
// TESTING
//  1. sw addr=0x10, wdata=0xDEADBEEF, ready=1
//     -> bus_addr=0x10, be=1111; stall high 2 cycles; no error.
//  2. lb addr=0x13, rdata word=0x80FF_0000, rvalid 3 cycles after handshake
//     -> rdata_o=0xFFFFFF80; lbu gives 0x00000080.
//  3. sh addr=0x22, wdata=0x1234
//     -> be=1100, bus_wdata=0x12341234.
//     lh addr=0x22 on word 0xABCD0000 -> rdata_o=0xFFFFABCD.
//  4. lw addr=0x6
//     -> misalign_o pulses once; bus_valid_o never asserted; stall_o stays 0.
//  5. TIMEOUT=4, ready held 0
//     -> bus_valid_o drops after 4 REQ cycles; bus_err_o=1 in DONE; rdata_o=0.
//  6. rst_n low during WAIT
//     -> next cycle IDLE, all outputs 0; late rvalid ignored; next sw completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings and the load/store unit state type.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size; anything other than byte/half is a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store enables/data and misalign check,
// plus load lane extraction with sign/zero extension. Purely combinational, no flow control.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    misalign   = 1'b0;
    case (req_funct3[1:0])
      SZ_BYTE: begin
        be         = 4'b0001 << req_off;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << req_off;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = req_off[0];
      end
      default: misalign = |req_off;
    endcase
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  // funct3[2] marks the unsigned variants; illegal encodings fall through as words.
  always_comb begin
    rdata_ext = shifted;
    case (ld_funct3[1:0])
      SZ_BYTE: rdata_ext = {{24{shifted[7] & ~ld_funct3[2]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{16{shifted[15] & ~ld_funct3[2]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one valid/ready data-memory access per request, core stalled until DONE.
// Store >= 2 stall cycles, load >= 3; waits on bus_ready_i/bus_rvalid_i, aborts after TIMEOUT.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwrite_i,
  input  logic              memread_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t        state_q, state_d;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        req_be;
  logic [31:0]       req_wdata, ld_data;
  logic              req_mis, req, timeout_hit;
  logic              stall, valid, misalign;

  lsu_align u_align (
    .req_funct3 (funct3_i),
    .req_off    (addr_i[1:0]),
    .wdata      (wdata_i),
    .be         (req_be),
    .wdata_lane (req_wdata),
    .misalign   (req_mis),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .rdata      (bus_rdata_i),
    .rdata_ext  (ld_data)
  );

  assign req         = memwrite_i | memread_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    valid    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_mis) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (timeout_hit) begin
          state_d = DONE;
        end else begin
          valid = 1'b1;
          if (bus_ready_i) state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timeout_hit || bus_rvalid_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (state_d == REQ) begin
            we_q    <= memwrite_i;
            addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            be_q    <= req_be;
            wdata_q <= req_wdata;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) err_q <= 1'b1;
          else if (state_q == WAIT && bus_rvalid_i) rdata_q <= ld_data;
        end
        default: ;
      endcase
    end
  end

  // Gate with rst_n so an abort is visible in the same cycle reset is asserted.
  assign stall_o     = rst_n & stall;
  assign misalign_o  = rst_n & misalign;
  assign bus_valid_o = rst_n & valid;
  assign bus_we_o    = bus_valid_o & we_q;
  assign bus_addr_o  = bus_valid_o ? addr_q  : '0;
  assign bus_be_o    = bus_valid_o ? be_q    : '0;
  assign bus_wdata_o = bus_valid_o ? wdata_q : '0;
  assign rdata_o     = (state_q == DONE) ? rdata_q : '0;
  assign bus_err_o   = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model.
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memwrite = 1'b0, memread = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err, bus_valid, bus_we;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  bit          exp_active = 1'b0;
  bit          exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  logic [3:0]  exp_be = '0;
  int          vcyc = 0;
  logic [3:0]  seen_be = '0;
  logic [31:0] seen_wd = '0, seen_addr = '0;
  int          last_stall = 0;
  logic [31:0] last_rdata = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memwrite_i   (memwrite),
    .memread_i    (memread),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .stall_o      (stall),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: access size in bytes and the lane rules as plain arithmetic.
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % model_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = ((8'd1 << model_size(f3)) - 8'd1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (model_size(f3))
      1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int         sz;
    logic [63:0] v, lim;
    sz = model_size(f3);
    v  = {32'b0, word} >> (8 * int'(a[1:0]));
    if (sz == 4) return v[31:0];
    lim = 64'd1 << (8 * sz);
    v   = v % lim;
    if (!f3[2] && v >= (lim >> 1)) v = v - lim;
    return v[31:0];
  endfunction

  // Every cycle the bus carries a request, its payload must match the model.
  always @(negedge clk) begin
    if (bus_valid) begin
      if (!exp_active) begin
        chk("spurious_valid", 32'(bus_valid), 32'd0);
      end else begin
        vcyc++;
        seen_be   = bus_be;
        seen_wd   = bus_wdata;
        seen_addr = bus_addr;
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_be", 32'(bus_be), 32'(exp_be));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wd);
      end
    end
  end

  task automatic run(input string nm, input bit we, input bit rd, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int rdy_dly,
                     input int rv_dly, input logic [31:0] word);
    bit load, mis, err, hs, hs_now, done;
    int exp_stall, exp_vcyc, vcnt, wcnt, stall_cnt;
    load      = rd && !we;
    mis       = model_mis(f3, a);
    err       = !mis && ((rdy_dly >= TMO) || (load && (rdy_dly + rv_dly >= TMO)));
    exp_stall = mis ? 0 : 1 + (err ? TMO + 1 : rdy_dly + 1 + (load ? rv_dly : 0));
    exp_vcyc  = mis ? 0 : ((rdy_dly >= TMO) ? TMO : rdy_dly + 1);
    hs = 0; hs_now = 0; done = 0; vcnt = 0; wcnt = 0; stall_cnt = 0;

    @(posedge clk); #2;
    vcyc       = 0;
    memwrite   = we;
    memread    = rd;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    bus_rdata  = word;
    exp_active = !mis;
    exp_we     = we;
    exp_addr   = a & 32'hFFFF_FFFC;
    exp_be     = model_be(f3, a);
    exp_wd     = model_wd(f3, wd);

    for (int c = 0; c < 24 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #2;
        if (hs_now) hs = 1;
        if (hs && load) wcnt++;
        bus_rvalid = load && hs && (wcnt == rv_dly);
        bus_ready  = !hs && bus_valid && (vcnt >= rdy_dly);
        if (bus_valid) vcnt++;
      end
      @(negedge clk);
      hs_now = bus_valid && bus_ready;
      if (c == 0) chk({nm, " misalign"}, 32'(misalign), 32'(mis));
      if (stall) begin
        stall_cnt++;
      end else if (mis) begin
        done = 1;
      end else if (c > 0) begin
        chk({nm, " bus_err"}, 32'(bus_err), 32'(err));
        if (load) chk({nm, " rdata"}, rdata, err ? 32'd0 : model_load(f3, a, word));
        last_rdata = rdata;
        done = 1;
      end
    end
    if (!done) chk({nm, " completion"}, 32'd0, 32'd1);
    chk({nm, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk({nm, " valid_cycles"}, 32'(vcyc), 32'(exp_vcyc));
    last_stall = stall_cnt;

    @(posedge clk); #2;
    memwrite   = 1'b0;
    memread    = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk({nm, " misalign_after"}, 32'(misalign), 32'd0);
    chk({nm, " bus_err_after"}, 32'(bus_err), 32'd0);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, " stall"}, 32'(stall), 32'd0);
    chk({nm, " valid"}, 32'(bus_valid), 32'd0);
    chk({nm, " we"}, 32'(bus_we), 32'd0);
    chk({nm, " addr"}, bus_addr, 32'd0);
    chk({nm, " be"}, 32'(bus_be), 32'd0);
    chk({nm, " wdata"}, bus_wdata, 32'd0);
    chk({nm, " rdata"}, rdata, 32'd0);
    chk({nm, " err"}, 32'(bus_err), 32'd0);
    chk({nm, " misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // sw to an aligned word, slave ready at once
    run("sw", 1, 0, F3_SW, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h0);
    chk("sw lit_addr", seen_addr, 32'h10);
    chk("sw lit_be", 32'(seen_be), 32'hF);
    chk("sw lit_wdata", seen_wd, 32'hDEAD_BEEF);
    chk("sw lit_stall", 32'(last_stall), 32'd2);

    // signed and unsigned byte loads from the top lane
    run("lb", 0, 1, F3_LB, 32'h13, 32'h0, 0, 3, 32'h80FF_0000);
    chk("lb lit_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lb lit_be", 32'(seen_be), 32'h8);
    run("lbu", 0, 1, F3_LBU, 32'h13, 32'h0, 0, 3, 32'h80FF_0000);
    chk("lbu lit_rdata", last_rdata, 32'h0000_0080);

    // halfword store and load in the upper half
    run("sh", 1, 0, F3_SH, 32'h22, 32'h0000_1234, 1, 1, 32'h0);
    chk("sh lit_be", 32'(seen_be), 32'hC);
    chk("sh lit_wdata", seen_wd, 32'h1234_1234);
    run("lh", 0, 1, F3_LH, 32'h22, 32'h0, 0, 1, 32'hABCD_0000);
    chk("lh lit_rdata", last_rdata, 32'hFFFF_ABCD);
    chk("lh lit_stall", 32'(last_stall), 32'd3);

    // misaligned accesses never reach the bus
    run("lw_mis", 0, 1, F3_LW, 32'h6, 32'h0, 0, 1, 32'h0);
    run("sh_mis", 1, 0, F3_SH, 32'h21, 32'h55AA, 0, 1, 32'h0);

    // more lanes, delays and corner encodings
    run("sb", 1, 0, F3_SB, 32'h101, 32'h0000_00A5, 2, 1, 32'h0);
    chk("sb lit_wdata", seen_wd, 32'hA5A5_A5A5);
    run("lhu", 0, 1, F3_LHU, 32'h2, 32'h0, 1, 2, 32'h8001_1234);
    chk("lhu lit_rdata", last_rdata, 32'h0000_8001);
    run("both_is_write", 1, 1, F3_SW, 32'h40, 32'h0BAD_F00D, 0, 1, 32'h0);
    run("illegal_f3", 0, 1, 3'b111, 32'h8, 32'h0, 0, 1, 32'h8899_AABB);
    chk("illegal_f3 lit_rdata", last_rdata, 32'h8899_AABB);

    // timeouts: slave never ready, and read data that never comes
    run("tmo_write", 1, 0, F3_SW, 32'h30, 32'h1111_2222, 99, 1, 32'h0);
    chk("tmo_write lit_stall", 32'(last_stall), 32'd6);
    run("tmo_read", 0, 1, F3_LW, 32'h34, 32'h0, 0, 9, 32'hFFFF_FFFF);
    chk("tmo_read lit_rdata", last_rdata, 32'd0);

    // reset in WAIT aborts the load; a late rvalid must be ignored
    @(posedge clk); #2;
    memread    = 1'b1;
    funct3     = F3_LW;
    addr       = 32'h48;
    bus_rdata  = 32'h1234_5678;
    exp_active = 1'b1;
    exp_we     = 1'b0;
    exp_addr   = 32'h48;
    exp_be     = 4'hF;
    @(posedge clk); #2;
    bus_ready = 1'b1;
    @(posedge clk); #2;
    bus_ready  = 1'b0;
    rst_n      = 1'b0;
    memread    = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("rst_wait stall", 32'(stall), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rst_wait idle");
    @(posedge clk); #2;
    bus_rvalid = 1'b1;
    @(negedge clk);
    check_quiet("late_rvalid");
    @(posedge clk); #2;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check_quiet("late_rvalid_after");

    run("sw_after_rst", 1, 0, F3_SW, 32'h50, 32'hCAFE_0001, 0, 1, 32'h0);
    chk("sw_after_rst lit_stall", 32'(last_stall), 32'd2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
